// File: rtl/nor_gate_mux.sv
// Bitwise NOR built solely from 2:1 mux cells, with a registered,
// enable-qualified copy of the result and a one-cycle valid flag.

module mux2_cell (
   input  logic sel,
   input  logic in0,
   input  logic in1,
   output logic y
);
   assign y = sel ? in1 : in0;
endmodule

module nor_gate_mux #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             y_valid
);
   logic [WIDTH-1:0] nb;

   // Inner mux inverts b; outer mux forces 0 whenever a is set.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      mux2_cell u_inv (.sel(b[i]), .in0(1'b1),  .in1(1'b0), .y(nb[i]));
      mux2_cell u_nor (.sel(a[i]), .in0(nb[i]), .in1(1'b0), .y(y[i]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         y_valid <= 1'b0;
      end else begin
         if (en) y_q <= y;
         y_valid <= en;
      end
   end
endmodule

// File: tb/tb_nor_gate_mux.sv
// Directed checks of nor_gate_mux at WIDTH=1 and WIDTH=4.

module tb_nor_gate_mux;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       a1, b1;
   logic       y1, yq1, yv1;
   logic [3:0] a4, b4;
   logic [3:0] y4, yq4;
   logic       yv4;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   always #5 clk = ~clk;

   nor_gate_mux #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en),
      .y(y1), .y_q(yq1), .y_valid(yv1)
   );

   nor_gate_mux #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en),
      .y(y4), .y_q(yq4), .y_valid(yv4)
   );

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      @(posedge clk); #1;
      total_cnt++;
      if (yq1 !== 1'b0) $display("FAIL reset_yq1 got %b exp 0", yq1); else pass_cnt++;
      total_cnt++;
      if (yv1 !== 1'b0) $display("FAIL reset_yv1 got %b exp 0", yv1); else pass_cnt++;
      total_cnt++;
      if (yq4 !== 4'h0) $display("FAIL reset_yq4 got %b exp 0000", yq4); else pass_cnt++;
      total_cnt++;
      if (yv4 !== 1'b0) $display("FAIL reset_yv4 got %b exp 0", yv4); else pass_cnt++;
      @(negedge clk);
      en = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_truth_table();
      logic [1:0] ab [4]   = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic       expy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         a1 = ab[i][1]; b1 = ab[i][0];
         #10;
         total_cnt++;
         if (y1 !== expy[i])
            $display("FAIL truth_a%0b_b%0b got %b exp %b", a1, b1, y1, expy[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_capture();
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b0; en = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (yq1 !== 1'b1) $display("FAIL capture_yq got %b exp 1", yq1); else pass_cnt++;
      total_cnt++;
      if (yv1 !== 1'b1) $display("FAIL capture_valid got %b exp 1", yv1); else pass_cnt++;
      @(negedge clk);
      en = 1'b0; a1 = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (yq1 !== 1'b1) $display("FAIL hold_yq got %b exp 1", yq1); else pass_cnt++;
      total_cnt++;
      if (yv1 !== 1'b0) $display("FAIL hold_valid got %b exp 0", yv1); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      #2;
      a1 = 1'b0; b1 = 1'b0;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (yq1 !== 1'b0) $display("FAIL async_rst_yq got %b exp 0", yq1); else pass_cnt++;
      total_cnt++;
      if (yv1 !== 1'b0) $display("FAIL async_rst_valid got %b exp 0", yv1); else pass_cnt++;
      total_cnt++;
      if (y1 !== 1'b1) $display("FAIL live_y_in_reset got %b exp 1", y1); else pass_cnt++;
      en = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (yq1 !== 1'b0) $display("FAIL rst_overrides_en got %b exp 0", yq1); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
   endtask

   task automatic test_vector();
      @(negedge clk);
      a4 = 4'b0011; b4 = 4'b0101;
      #1;
      total_cnt++;
      if (y4 !== 4'b1000) $display("FAIL vec_y got %b exp 1000", y4); else pass_cnt++;
      en = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (yq4 !== 4'b1000) $display("FAIL vec_yq got %b exp 1000", yq4); else pass_cnt++;
      total_cnt++;
      if (yv4 !== 1'b1) $display("FAIL vec_valid got %b exp 1", yv4); else pass_cnt++;
   endtask

   task automatic test_exhaustive();
      logic [7:0] v;
      logic [3:0] exp_y;
      int         errs = 0;
      en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         v = i[7:0];
         a4 = v[7:4]; b4 = v[3:0];
         exp_y = ~(v[7:4] | v[3:0]);
         #1;
         total_cnt++;
         if (y4 !== exp_y) begin
            if (errs < 10)
               $display("FAIL sweep_y a=%b b=%b got %b exp %b", a4, b4, y4, exp_y);
            errs++;
         end else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++;
         if (yq4 !== exp_y || yv4 !== 1'b1) begin
            if (errs < 10)
               $display("FAIL sweep_yq a=%b b=%b got %b/%b exp %b/1",
                        a4, b4, yq4, yv4, exp_y);
            errs++;
         end else pass_cnt++;
      end
      @(negedge clk);
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_truth_table();
      test_capture();
      test_async_reset();
      test_vector();
      test_exhaustive();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
